// File: rtl/bp_proc_sched.sv
// Backprop processor-set sequencer: walks blocks of z neurons, fo accumulation cycles each.
// Optional stall counter output enabled by defining BP_SCHED_STALL_CNT_EN.
module bp_proc_sched #(
    parameter int p  = 8,
    parameter int z  = 4,
    parameter int fo = 2,
    localparam int NB = p / z,
    localparam int CW = (NB * fo > 1) ? $clog2(NB * fo) : 1,
    localparam int BW = (NB > 1) ? $clog2(NB) : 1,
    localparam int FW = (fo > 1) ? $clog2(fo) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stall,
`ifdef BP_SCHED_STALL_CNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          busy,
    output logic          done,
    output logic          proc_en,
    output logic          pd_sel_zero,
    output logic          pd_we,
    output logic          delp_we,
    output logic [BW-1:0] delp_addr,
    output logic [CW-1:0] wt_addr,
    output logic [FW-1:0] fo_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic       active;
    logic       last_fo;
    logic       last_blk;

    assign active   = (state == S_RUN) && !stall;
    assign last_fo  = (fo_idx == FW'(fo - 1));
    assign last_blk = (delp_addr == BW'(NB - 1));

    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign proc_en     = active;
    assign pd_we       = active;
    assign pd_sel_zero = active && (fo_idx == '0);
    assign delp_we     = active && last_fo;

    // Counters are cleared on the final cycle so nothing ever runs past its terminal value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wt_addr   <= '0;
            delp_addr <= '0;
            fo_idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        wt_addr   <= '0;
                        delp_addr <= '0;
                        fo_idx    <= '0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (last_fo && last_blk) begin
                            state     <= S_DONE;
                            wt_addr   <= '0;
                            delp_addr <= '0;
                            fo_idx    <= '0;
                        end else begin
                            wt_addr <= wt_addr + CW'(1);
                            if (last_fo) begin
                                fo_idx    <= '0;
                                delp_addr <= delp_addr + BW'(1);
                            end else begin
                                fo_idx <= fo_idx + FW'(1);
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BP_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (state == S_IDLE && start)
            stall_cnt <= '0;
        else if (state == S_RUN && stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bp_proc_sched.sv
// Bench for bp_proc_sched: vector table through a scoreboard queue, plus hand sequences
// for async reset, back-to-back passes and an fo=1 instance.
module tb_bp_proc_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, stall, start1, stall1;

    logic       busy, done, proc_en, pd_sel_zero, pd_we, delp_we;
    logic [0:0] delp_addr, fo_idx;
    logic [1:0] wt_addr;
    logic [15:0] scnt0, scnt1;

    logic       busy1, done1, proc_en1, pd_sel_zero1, pd_we1, delp_we1;
    logic [0:0] delp_addr1, fo_idx1, wt_addr1;

    bp_proc_sched #(.p(8), .z(4), .fo(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
`ifdef BP_SCHED_STALL_CNT_EN
        .stall_cnt(scnt0),
`endif
        .busy(busy), .done(done), .proc_en(proc_en), .pd_sel_zero(pd_sel_zero),
        .pd_we(pd_we), .delp_we(delp_we), .delp_addr(delp_addr),
        .wt_addr(wt_addr), .fo_idx(fo_idx)
    );

    bp_proc_sched #(.p(8), .z(4), .fo(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .stall(stall1),
`ifdef BP_SCHED_STALL_CNT_EN
        .stall_cnt(scnt1),
`endif
        .busy(busy1), .done(done1), .proc_en(proc_en1), .pd_sel_zero(pd_sel_zero1),
        .pd_we(pd_we1), .delp_we(delp_we1), .delp_addr(delp_addr1),
        .wt_addr(wt_addr1), .fo_idx(fo_idx1)
    );

    // {busy,done,proc_en,pd_sel_zero,pd_we,delp_we,delp_addr,wt_addr,fo_idx}
    wire [31:0] o0 = {22'd0, busy, done, proc_en, pd_sel_zero, pd_we, delp_we,
                      delp_addr, wt_addr, fo_idx};
    wire [31:0] o1 = {23'd0, busy1, done1, proc_en1, pd_sel_zero1, pd_we1, delp_we1,
                      delp_addr1, wt_addr1, fo_idx1};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        start;
        logic        stall;
        logic [31:0] mask;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t v(input logic st, input logic sl, input logic [5:0] s,
                               input logic da, input logic [1:0] wa, input logic fi,
                               input logic ca);
        vec_t r;
        r.start = st;
        r.stall = sl;
        r.mask  = ca ? 32'h3FF : 32'h3F0;
        r.exp   = {22'd0, s, da, wa, fi};
        return r;
    endfunction

    // strobe groups {busy,done,proc_en,pd_sel_zero,pd_we,delp_we}
    localparam logic [5:0] IDL = 6'b000000;
    localparam logic [5:0] A1  = 6'b101110;
    localparam logic [5:0] A2  = 6'b101011;
    localparam logic [5:0] ST  = 6'b100000;
    localparam logic [5:0] DN  = 6'b010000;

    localparam int NV = 23;
    vec_t tbl[NV];
    vec_t sb[$];

    initial begin
        vec_t e;
        int   ph;

        tbl[0]  = v(1, 0, IDL, 0, 2'd0, 0, 0);
        tbl[1]  = v(0, 0, A1,  0, 2'd0, 0, 1);
        tbl[2]  = v(0, 0, A2,  0, 2'd1, 1, 1);
        tbl[3]  = v(0, 0, A1,  1, 2'd2, 0, 1);
        tbl[4]  = v(0, 0, A2,  1, 2'd3, 1, 1);
        tbl[5]  = v(0, 0, DN,  0, 2'd0, 0, 0);
        tbl[6]  = v(1, 0, IDL, 0, 2'd0, 0, 0);
        tbl[7]  = v(0, 0, A1,  0, 2'd0, 0, 1);
        tbl[8]  = v(1, 1, ST,  0, 2'd1, 1, 1);
        tbl[9]  = v(0, 1, ST,  0, 2'd1, 1, 1);
        tbl[10] = v(0, 0, A2,  0, 2'd1, 1, 1);
        tbl[11] = v(1, 0, A1,  1, 2'd2, 0, 1);
        tbl[12] = v(0, 0, A2,  1, 2'd3, 1, 1);
        tbl[13] = v(0, 0, DN,  0, 2'd0, 0, 0);
        tbl[14] = v(0, 1, IDL, 0, 2'd0, 0, 0);
        tbl[15] = v(1, 0, IDL, 0, 2'd0, 0, 0);
        tbl[16] = v(0, 0, A1,  0, 2'd0, 0, 1);
        tbl[17] = v(0, 0, A2,  0, 2'd1, 1, 1);
        tbl[18] = v(0, 0, A1,  1, 2'd2, 0, 1);
        tbl[19] = v(0, 1, ST,  1, 2'd3, 1, 1);
        tbl[20] = v(0, 0, A2,  1, 2'd3, 1, 1);
        tbl[21] = v(0, 0, DN,  0, 2'd0, 0, 0);
        tbl[22] = v(0, 0, IDL, 0, 2'd0, 0, 0);

        // reset held with start asserted
        reset_n = 1'b0; start = 1'b1; stall = 1'b0; start1 = 1'b0; stall1 = 1'b0;
        repeat (3) begin
            @(posedge clk); #4;
            chk("reset_outs", o0, 32'd0);
            chk("reset_outs_fo1", o1, 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0; reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            start = tbl[i].start;
            stall = tbl[i].stall;
            sb.push_back(tbl[i]);
            #3;
            e = sb.pop_front();
            chk($sformatf("vec%0d", i), o0 & e.mask, e.exp & e.mask);
`ifdef BP_SCHED_STALL_CNT_EN
            if (i == 13 || i == 15) chk($sformatf("stall_cnt%0d", i), 32'(scnt0), 32'd2);
            if (i == 21) chk("stall_cnt21", 32'(scnt0), 32'd1);
`endif
        end

        // async reset in cycle 2 of a pass
        start = 1'b1; stall = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1 chk("async_rst_outs", o0, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #3;
            chk("no_done_after_rst", {busy, done}, 32'd0);
        end
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            #3 chk($sformatf("rerun_wt%0d", n), {busy, wt_addr}, 32'h4 | n);
            @(posedge clk); #1;
        end
        #3 chk("rerun_done", {busy, done}, 32'd1);

        // start held high: pass = 4 active + DONE + IDLE
        @(posedge clk); #1 start = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #3;
            ph = n % 6;
            chk($sformatf("b2b_done%0d", n), 32'(done), 32'(ph == 5));
            chk($sformatf("b2b_busy%0d", n), 32'(busy), 32'(ph >= 1 && ph <= 4));
            if (ph >= 1 && ph <= 4)
                chk($sformatf("b2b_wt%0d", n), 32'(wt_addr), 32'(ph - 1));
        end
        #1 start = 1'b0;
        repeat (6) @(posedge clk);

        // fo=1 instance: {b,d,pe,psz,pw,dw,da,wa,fi}
        #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        #3 chk("fo1_c1", o1, 32'b1_0_1_1_1_1_0_0_0);
        @(posedge clk); #4 chk("fo1_c2", o1, 32'b1_0_1_1_1_1_1_1_0);
        @(posedge clk); #4 chk("fo1_c3", o1 & 32'h1F8, 32'b0_1_0_0_0_0_0_0_0);
        @(posedge clk); #4 chk("fo1_c4", o1 & 32'h1F8, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
